point_unmap_pipe: RTL and testbench
===================================

// Module: point_unmap_pipe
// PURPOSE
//  Elastic 2-stage successor to the combinational octant swapback. Takes line-generator
//  deltas (dx,dy) normalised to the generator frame, plus octant code and line origin.
//  Undoes swap and reflection, adds the origin, and optionally clips to the screen.
//  Sits between the Bresenham point generator and the framebuffer write port.
// PARAMETERS
//  DW    10   width of unsigned generator deltas dx/dy
//  XW    10   width of screen x coordinate
//  YW    9    width of screen y coordinate
//  XMAX  639  last valid screen column (clip bound, CLIP_EN only)
//  YMAX  479  last valid screen row (clip bound, CLIP_EN only)
// PORTS
//  clk        in   1    system clock
//  rst_n      in   1    asynchronous active-low reset
//  in_valid   in   1    input beat valid
//  in_ready   out  1    block can accept beat
//  dx, dy     in   DW   generator-frame deltas (unsigned)
//  octant     in   3    line octant code
//  clr_color  in   1    screen-clear beat: raw passthrough
//  x0         in   XW   line origin x
//  y0         in   YW   line origin y
//  in_last    in   1    final point of line
//  out_valid  out  1    output beat valid
//  out_ready  in   1    downstream accepts beat
//  x_f        out  XW   screen x
//  y_f        out  YW   screen y
//  out_last   out  1    forwarded in_last
//  out_clr    out  1    forwarded clr_color
//  line_done  out  1    1-cycle pulse when a last beat leaves stage 2 (emitted or dropped)
//  clip_cnt   out  16   dropped-point count (CLIP_EN only)
// BEHAVIOUR
//  - Reset: all stage valids 0, out_valid=0, x_f=0, y_f=0, out_last=0, out_clr=0,
//    line_done=0, clip_cnt=0. Reset mid-line discards in-flight beats; no partial output.
//  - Handshake: a beat transfers when valid&ready. Each stage is ready when !v | next ready.
//    in_ready = !s1_v | s2_ready. No combinational path from in_valid to out_valid.
//    in_ready depends combinationally on out_ready. Holds 2 beats max. Order preserved;
//    no loss or duplication.
//  - Latency: 2 cycles accept-to-out_valid when unstalled. Throughput: 1 beat/cycle.
//  - Stage 1 (swap/reflect):
//    - swap = octant in {0,3,4,7}: (u,v)=(dy,dx); otherwise (u,v)=(dx,dy).
//    - negx = octant in {2,3,4,5}; negy = octant in {4,5,6,7}.
//    - u and v are sign-extended to DW+2 and negated per negx/negy.
//  - clr_color=1: no swap, no negate, no origin add; x_f=dx[XW-1:0], y_f=dy[YW-1:0].
//  - Stage 2: sx = x0 + u, sy = y0 + v, signed at max(XW,DW)+2 bits.
//  - Output regs x_f, y_f, out_last, out_clr load only on stage-2 advance.
//    They hold stable while out_valid & !out_ready.
// CONFIGURATION
//  Macro POINT_UNMAP_CLIP_EN.
//  - Defined:
//    - A non-clr beat with sx<0, sx>XMAX, sy<0 or sy>YMAX is dropped in stage 2.
//    - Dropped beats never assert out_valid. clip_cnt increments by 1 per drop.
//    - clip_cnt saturates at 16'hFFFF. line_done still pulses if the dropped beat was last.
//  - Undefined:
//    - No drop; sx and sy are truncated to XW/YW bits (wrap-around).
//    - clip_cnt port is absent.
// STRUCTURE
//  - Shared package rast_pkg:
//    - octant localparams OCT0..OCT7.
//    - functions oct_swap(), oct_negx(), oct_negy().
//    - default XW/YW/XMAX/YMAX constants, shared with the generator.
//  - Sub-module rast_pipe_reg (parametrised-width valid/ready stage register).
//    Instantiated twice.
// TESTING
//  1 oct0, dx=5, dy=2, origin(100,50) -> (102,55), 2 cycles after accept.
//    oct5 same inputs -> (95,48). oct3 same inputs -> (98,55).
//  2 clr_color=1, oct0, dx=639, dy=479, origin(7,7) -> (639,479), out_clr=1.
//  3 oct4, dx=5, dy=0, origin(1,1), in_last=1:
//    - CLIP_EN: no out_valid, clip_cnt=1, line_done pulses once.
//    - no CLIP_EN: emits (1,508).
//  4 out_ready=0 for 3 cycles, in_valid=1 with beats A,B,C:
//    in_ready drops after A,B accepted. Then out_ready=1 -> A,B,C in order, x_f stable while stalled.
//  5 rst_n low with 2 beats in flight, release -> out_valid=0, clip_cnt=0.
//    Next beat emerges after 2 cycles.
//  6 random back-to-back stream, random out_ready -> scoreboard matches reference model,
//    1 beat/cycle when out_ready=1.

Source files
------------

// File: rtl/rast_pkg.sv
// Shared rasteriser definitions: octant codes, octant decode helpers and the
// default screen geometry used by the line generator and the unmap pipe.
package rast_pkg;

    localparam int RAST_DW   = 10;
    localparam int RAST_XW   = 10;
    localparam int RAST_YW   = 9;
    localparam int RAST_XMAX = 639;
    localparam int RAST_YMAX = 479;

    localparam logic [2:0] OCT0 = 3'd0;
    localparam logic [2:0] OCT1 = 3'd1;
    localparam logic [2:0] OCT2 = 3'd2;
    localparam logic [2:0] OCT3 = 3'd3;
    localparam logic [2:0] OCT4 = 3'd4;
    localparam logic [2:0] OCT5 = 3'd5;
    localparam logic [2:0] OCT6 = 3'd6;
    localparam logic [2:0] OCT7 = 3'd7;

    // Generator stepped along y as its major axis: swap u/v back.
    function automatic logic oct_swap(input logic [2:0] oct);
        return oct inside {OCT0, OCT3, OCT4, OCT7};
    endfunction

    function automatic logic oct_negx(input logic [2:0] oct);
        return oct inside {OCT2, OCT3, OCT4, OCT5};
    endfunction

    function automatic logic oct_negy(input logic [2:0] oct);
        return oct inside {OCT4, OCT5, OCT6, OCT7};
    endfunction

endpackage

// File: rtl/rast_pipe_reg.sv
// One elastic valid/ready pipeline stage of parametrised payload width.
// Accepts whenever empty or when the downstream consumer takes the held beat.
module rast_pipe_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         v_q;
    logic [W-1:0] d_q;

    assign in_ready  = !v_q || out_ready;
    assign out_valid = v_q;
    assign out_data  = d_q;

    // Valid/payload register; payload only changes when a new beat lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= 1'b0;
            d_q <= '0;
        end else if (in_ready) begin
            v_q <= in_valid;
            if (in_valid) d_q <= in_data;
        end
    end

endmodule

// File: rtl/point_unmap_pipe.sv
// Two-stage elastic octant unmap: undoes the generator's swap/reflection,
// adds the line origin and hands screen points to the framebuffer port.
// Optional screen clipping with a drop counter: define POINT_UNMAP_CLIP_EN.
module point_unmap_pipe
    import rast_pkg::*;
#(
    parameter int DW   = RAST_DW,
    parameter int XW   = RAST_XW,
    parameter int YW   = RAST_YW
`ifdef POINT_UNMAP_CLIP_EN
    ,
    parameter int XMAX = RAST_XMAX,
    parameter int YMAX = RAST_YMAX
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dx,
    input  logic [DW-1:0] dy,
    input  logic [2:0]    octant,
    input  logic          clr_color,
    input  logic [XW-1:0] x0,
    input  logic [YW-1:0] y0,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [XW-1:0] x_f,
    output logic [YW-1:0] y_f,
    output logic          out_last,
    output logic          out_clr,
    output logic          line_done
`ifdef POINT_UNMAP_CLIP_EN
    ,
    output logic [15:0]   clip_cnt
`endif
);

    localparam int UW  = DW + 2;
    localparam int MW  = (XW > YW) ? XW : YW;
    localparam int SW  = ((MW > DW) ? MW : DW) + 2;
    localparam int S1W = 2*UW + XW + YW + 2;
    localparam int S2W = XW + YW + 2;

    logic                 swap, negx, negy;
    logic signed [UW-1:0] a, b, u_d, v_d;

    // Undo octant swap and reflection; clear beats bypass both untouched.
    always_comb begin
        swap = !clr_color && oct_swap(octant);
        negx = !clr_color && oct_negx(octant);
        negy = !clr_color && oct_negy(octant);
        a    = $signed({2'b00, dx});
        b    = $signed({2'b00, dy});
        u_d  = swap ? b : a;
        v_d  = swap ? a : b;
        if (negx) u_d = -u_d;
        if (negy) v_d = -v_d;
    end

    logic [S1W-1:0]       s1_in, s1_out;
    logic                 s1_vld, s2_ready, s2_in_v, drop, drop_fire;
    logic signed [UW-1:0] s1_du, s1_dv;
    logic [XW-1:0]        s1_x0;
    logic [YW-1:0]        s1_y0;
    logic                 s1_last, s1_clr;

    assign s1_in = {u_d, v_d, x0, y0, in_last, clr_color};

    rast_pipe_reg #(.W(S1W)) u_s1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (s1_in),
        .out_valid (s1_vld),
        .out_ready (s2_ready),
        .out_data  (s1_out)
    );

    assign {s1_du, s1_dv, s1_x0, s1_y0, s1_last, s1_clr} = s1_out;

    logic signed [SW-1:0] sx, sy;

    // Origin add at full signed width so off-screen results stay visible.
    always_comb begin
        sx = SW'(s1_du);
        sy = SW'(s1_dv);
        if (!s1_clr) begin
            sx = $signed(SW'(s1_x0)) + SW'(s1_du);
            sy = $signed(SW'(s1_y0)) + SW'(s1_dv);
        end
    end

`ifdef POINT_UNMAP_CLIP_EN
    localparam logic signed [SW-1:0] XMAX_S = SW'(XMAX);
    localparam logic signed [SW-1:0] YMAX_S = SW'(YMAX);
    assign drop = s1_vld && !s1_clr &&
                  (sx[SW-1] || (sx > XMAX_S) || sy[SW-1] || (sy > YMAX_S));
`else
    // Without clipping the sum wraps; the high bits are simply discarded.
    logic unused_hi;
    assign unused_hi = ^{sx[SW-1:XW], sy[SW-1:YW]};
    assign drop      = 1'b0;
`endif

    // A dropped beat retires from stage 1 only when stage 2 would have taken it.
    assign drop_fire = drop && s2_ready;
    assign s2_in_v   = s1_vld && !drop;

    logic [S2W-1:0] s2_in, s2_out;
    assign s2_in = {sx[XW-1:0], sy[YW-1:0], s1_last, s1_clr};

    rast_pipe_reg #(.W(S2W)) u_s2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s2_in_v),
        .in_ready  (s2_ready),
        .in_data   (s2_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (s2_out)
    );

    assign {x_f, y_f, out_last, out_clr} = s2_out;

    logic line_done_q, line_done_d;
    assign line_done_d = (out_valid && out_ready && out_last) || (drop_fire && s1_last);
    assign line_done   = line_done_q;

    // One-cycle end-of-line pulse, whether the last point was emitted or clipped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) line_done_q <= 1'b0;
        else        line_done_q <= line_done_d;
    end

`ifdef POINT_UNMAP_CLIP_EN
    logic [15:0] clip_cnt_q;
    assign clip_cnt = clip_cnt_q;

    // Saturating count of clipped points.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                    clip_cnt_q <= 16'd0;
        else if (drop_fire && clip_cnt_q != 16'hFFFF)  clip_cnt_q <= clip_cnt_q + 16'd1;
    end
`endif

endmodule

// File: tb/tb_point_unmap_pipe.sv
// Self-checking bench for point_unmap_pipe (default build or POINT_UNMAP_CLIP_EN).
module tb_point_unmap_pipe;

    localparam int DW = 10, XW = 10, YW = 9, XMAX = 639, YMAX = 479;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0, in_ready;
    logic [DW-1:0] dx = '0, dy = '0;
    logic [2:0]    octant = '0;
    logic          clr_color = 1'b0;
    logic [XW-1:0] x0 = '0;
    logic [YW-1:0] y0 = '0;
    logic          in_last = 1'b0;
    logic          out_valid, out_ready = 1'b1;
    logic [XW-1:0] x_f;
    logic [YW-1:0] y_f;
    logic          out_last, out_clr, line_done;
`ifdef POINT_UNMAP_CLIP_EN
    logic [15:0]   clip_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic          last;
        logic          clr;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    point_unmap_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .dx(dx), .dy(dy), .octant(octant), .clr_color(clr_color),
        .x0(x0), .y0(y0), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .x_f(x_f), .y_f(y_f), .out_last(out_last), .out_clr(out_clr),
        .line_done(line_done)
`ifdef POINT_UNMAP_CLIP_EN
        , .clip_cnt(clip_cnt)
`endif
    );

    // Reference: reflect/swap back in plain integer arithmetic.
    function automatic void model(input int dx_, input int dy_, input int oct_, input int clr_,
                                  input int x0_, input int y0_, output bit drop,
                                  output logic [XW-1:0] ex, output logic [YW-1:0] ey);
        int u, v, sx, sy;
        drop = 1'b0;
        if (clr_ != 0) begin
            sx = dx_; sy = dy_;
        end else begin
            if (oct_ == 0 || oct_ == 3 || oct_ == 4 || oct_ == 7) begin u = dy_; v = dx_; end
            else begin u = dx_; v = dy_; end
            if (oct_ >= 2 && oct_ <= 5) u = -u;
            if (oct_ >= 4) v = -v;
            sx = x0_ + u; sy = y0_ + v;
`ifdef POINT_UNMAP_CLIP_EN
            drop = (sx < 0) || (sx > XMAX) || (sy < 0) || (sy > YMAX);
`endif
        end
        ex = XW'(sx);
        ey = YW'(sy);
    endfunction

    task automatic drv(input int dx_, input int dy_, input int oct_, input int clr_,
                       input int x0_, input int y0_, input int last_);
        in_valid  = 1'b1;
        dx        = DW'(dx_);
        dy        = DW'(dy_);
        octant    = 3'(oct_);
        clr_color = (clr_ != 0);
        x0        = XW'(x0_);
        y0        = YW'(y0_);
        in_last   = (last_ != 0);
    endtask

    // Leaves the bench 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #20;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_cmp++;
        if ({x_f, y_f, out_last, out_clr, line_done} !== '0) begin
            n_err++; $display("FAIL reset_outputs got x=%0d y=%0d last=%b clr=%b ld=%b exp all 0",
                              x_f, y_f, out_last, out_clr, line_done);
        end
`ifdef POINT_UNMAP_CLIP_EN
        n_cmp++;
        if (clip_cnt !== 16'd0) begin n_err++; $display("FAIL reset_clip_cnt got=%0d exp=0", clip_cnt); end
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_octants();
        int oc[3] = '{0, 5, 3};
        int ex[3] = '{102, 95, 98};
        int ey[3] = '{55, 48, 55};
        for (int i = 0; i < 3; i++) begin
            drv(5, 2, oc[i], 0, 100, 50, 0);
            #1;
            n_cmp++;
            if (in_ready !== 1'b1) begin n_err++; $display("FAIL oct%0d_in_ready got=%b exp=1", oc[i], in_ready); end
            tick();
            in_valid = 1'b0;
            #1;
            n_cmp++;
            if (out_valid !== 1'b0) begin n_err++; $display("FAIL oct%0d_early_valid got=%b exp=0", oc[i], out_valid); end
            tick();
            #1;
            n_cmp++;
            if (out_valid !== 1'b1 || x_f !== XW'(ex[i]) || y_f !== YW'(ey[i]) || out_clr !== 1'b0) begin
                n_err++; $display("FAIL oct%0d_result got v=%b (%0d,%0d) clr=%b exp v=1 (%0d,%0d) clr=0",
                                  oc[i], out_valid, x_f, y_f, out_clr, ex[i], ey[i]);
            end
            tick();
        end
    endtask

    task automatic test_clr();
        drv(639, 479, 0, 1, 7, 7, 0);
        tick();
        in_valid = 1'b0;
        tick();
        #1;
        n_cmp++;
        if (out_valid !== 1'b1 || x_f !== 10'd639 || y_f !== 9'd479 || out_clr !== 1'b1) begin
            n_err++; $display("FAIL clr_passthrough got v=%b (%0d,%0d) clr=%b exp v=1 (639,479) clr=1",
                              out_valid, x_f, y_f, out_clr);
        end
        tick();
    endtask

    task automatic test_clip();
        int nv = 0, nld = 0;
        logic [XW-1:0] gx = '0;
        logic [YW-1:0] gy = '0;
        drv(5, 0, 4, 0, 1, 1, 1);
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (out_valid) begin nv++; gx = x_f; gy = y_f; end
            if (line_done) nld++;
            tick();
        end
        n_cmp++;
        if (nld != 1) begin n_err++; $display("FAIL clip_line_done got=%0d pulses exp=1", nld); end
`ifdef POINT_UNMAP_CLIP_EN
        n_cmp++;
        if (nv != 0) begin n_err++; $display("FAIL clip_drop got=%0d beats exp=0", nv); end
        n_cmp++;
        if (clip_cnt !== 16'd1) begin n_err++; $display("FAIL clip_cnt got=%0d exp=1", clip_cnt); end
`else
        n_cmp++;
        if (nv != 1 || gx !== 10'd1 || gy !== 9'd508) begin
            n_err++; $display("FAIL wrap_result got n=%0d (%0d,%0d) exp n=1 (1,508)", nv, gx, gy);
        end
`endif
    endtask

    task automatic test_stall();
        int xs[3] = '{11, 22, 33};
        int k = 0, nout = 0;
        bit acc;
        for (int c = 0; c < 12; c++) begin
            out_ready = (c >= 4);
            if (k < 3) drv(xs[k], k + 1, 1, 0, 0, 0, 0);
            else in_valid = 1'b0;
            #1;
            if (c == 3) begin
                n_cmp++;
                if (in_ready !== 1'b0 || k != 2) begin
                    n_err++; $display("FAIL stall_backpressure got in_ready=%b accepted=%0d exp 0/2", in_ready, k);
                end
            end
            if (c == 2 || c == 3) begin
                n_cmp++;
                if (out_valid !== 1'b1 || x_f !== 10'd11) begin
                    n_err++; $display("FAIL stall_hold c%0d got v=%b x=%0d exp v=1 x=11", c, out_valid, x_f);
                end
            end
            acc = in_valid && in_ready;
            if (out_valid && out_ready) begin
                n_cmp++;
                if (nout > 2 || x_f !== XW'(xs[nout > 2 ? 2 : nout])) begin
                    n_err++; $display("FAIL stall_order beat%0d got x=%0d", nout, x_f);
                end
                nout++;
            end
            tick();
            if (acc) k++;
        end
        n_cmp++;
        if (nout != 3) begin n_err++; $display("FAIL stall_count got=%0d exp=3", nout); end
    endtask

    task automatic test_reset_midline();
        int nv = 0;
        out_ready = 1'b0;
        drv(40, 4, 1, 0, 0, 0, 1);
        tick();
        drv(50, 5, 1, 0, 0, 0, 1);
        tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_async got v=%b exp=0", out_valid); end
`ifdef POINT_UNMAP_CLIP_EN
        n_cmp++;
        if (clip_cnt !== 16'd0) begin n_err++; $display("FAIL rstmid_clip_cnt got=%0d exp=0", clip_cnt); end
`endif
        tick(); tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (out_valid || line_done) nv++;
            tick();
        end
        n_cmp++;
        if (nv != 0) begin n_err++; $display("FAIL rstmid_leftover got=%0d cycles exp=0", nv); end
        drv(60, 6, 1, 0, 0, 0, 0);
        tick();
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_early got v=%b exp=0", out_valid); end
        tick();
        #1;
        n_cmp++;
        if (out_valid !== 1'b1 || x_f !== 10'd60 || y_f !== 9'd6) begin
            n_err++; $display("FAIL rstmid_next got v=%b (%0d,%0d) exp v=1 (60,6)", out_valid, x_f, y_f);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int nacc = 0, nout = 0, gaps = 0;
        bit drop;
        exp_t e;
        int r_dx, r_dy, r_oc;
        out_ready = 1'b1;
        for (int c = 0; c < 44; c++) begin
            if (c < 40) begin
                r_dx = $urandom_range(0, 50); r_dy = $urandom_range(0, 50); r_oc = $urandom_range(0, 7);
                drv(r_dx, r_dy, r_oc, 0, 300, 200, 0);
            end else in_valid = 1'b0;
            #1;
            if (in_valid && in_ready) begin
                nacc++;
                model(r_dx, r_dy, r_oc, 0, 300, 200, drop, e.x, e.y);
                e.last = 1'b0; e.clr = 1'b0;
                q.push_back(e);
            end
            if (c >= 2 && c < 40 && !out_valid) gaps++;
            if (out_valid && out_ready) begin
                nout++;
                n_cmp++;
                if (q.size() == 0) begin
                    n_err++; $display("FAIL b2b_extra got (%0d,%0d)", x_f, y_f);
                end else begin
                    e = q.pop_front();
                    if (x_f !== e.x || y_f !== e.y) begin
                        n_err++; $display("FAIL b2b_data got (%0d,%0d) exp (%0d,%0d)", x_f, y_f, e.x, e.y);
                    end
                end
            end
            tick();
        end
        n_cmp++;
        if (nacc != 40 || nout != 40 || gaps != 0) begin
            n_err++; $display("FAIL b2b_throughput got acc=%0d out=%0d gaps=%0d exp 40/40/0", nacc, nout, gaps);
        end
    endtask

    task automatic test_random();
        int r_dx = 0, r_dy = 0, r_oc = 0, r_clr = 0, r_x0 = 0, r_y0 = 0, r_last = 0;
        int n_drop = 0, exp_ld = 0, got_ld = 0;
        bit acc = 1'b0, drop;
        exp_t e;
        q.delete();
        for (int c = 0; c < 630; c++) begin
            if (c < 600) begin
                if (!in_valid || acc) begin
                    if ($urandom_range(0, 3) != 0) begin
                        r_clr  = ($urandom_range(0, 7) == 0);
                        r_dx   = r_clr != 0 ? $urandom_range(0, 1023) : $urandom_range(0, 300);
                        r_dy   = r_clr != 0 ? $urandom_range(0, 1023) : $urandom_range(0, 300);
                        r_oc   = $urandom_range(0, 7);
                        r_x0   = $urandom_range(0, 1023);
                        r_y0   = $urandom_range(0, 511);
                        r_last = ($urandom_range(0, 3) == 0);
                        drv(r_dx, r_dy, r_oc, r_clr, r_x0, r_y0, r_last);
                    end else in_valid = 1'b0;
                end
                out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            #1;
            acc = in_valid && in_ready;
            if (acc) begin
                model(r_dx, r_dy, r_oc, r_clr, r_x0, r_y0, drop, e.x, e.y);
                e.last = (r_last != 0); e.clr = (r_clr != 0);
                if (r_last != 0) exp_ld++;
                if (drop) n_drop++;
                else q.push_back(e);
            end
            if (line_done) got_ld++;
            if (out_valid && out_ready) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_err++; $display("FAIL rand_extra got (%0d,%0d)", x_f, y_f);
                end else begin
                    e = q.pop_front();
                    if ({x_f, y_f, out_last, out_clr} !== {e.x, e.y, e.last, e.clr}) begin
                        n_err++; $display("FAIL rand_data got (%0d,%0d) l=%b c=%b exp (%0d,%0d) l=%b c=%b",
                                          x_f, y_f, out_last, out_clr, e.x, e.y, e.last, e.clr);
                    end
                end
            end
            tick();
        end
        n_cmp++;
        if (q.size() != 0) begin n_err++; $display("FAIL rand_drain got=%0d pending exp=0", q.size()); end
        n_cmp++;
        if (got_ld != exp_ld) begin n_err++; $display("FAIL rand_line_done got=%0d exp=%0d", got_ld, exp_ld); end
`ifdef POINT_UNMAP_CLIP_EN
        n_cmp++;
        if (clip_cnt !== 16'(n_drop)) begin n_err++; $display("FAIL rand_clip_cnt got=%0d exp=%0d", clip_cnt, n_drop); end
`else
        n_cmp++;
        if (n_drop != 0) begin n_err++; $display("FAIL rand_model_drop got=%0d exp=0", n_drop); end
`endif
    endtask

    initial begin
        test_reset();
        test_octants();
        test_clr();
        test_clip();
        test_stall();
        test_reset_midline();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
